// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: lets instruction fetch and data load/store share one
// memory port. Only one access is in flight at a time. Each access holds the
// port for MEM_LAT cycles, then read data is captured and the owner gets a
// one-cycle valid pulse. Simultaneous requests are resolved round-robin
// (PRIORITY=0) or always in favour of the data port (PRIORITY=1).

module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MEM_LAT  = 1,
  parameter int PRIORITY = 0
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iFetchReq,
  input  logic [ADDR_W-1:0] iFetchAddr,
  output logic              oFetchGnt,
  output logic [DATA_W-1:0] oFetchRData,
  output logic              oFetchValid,
  input  logic              iDataReq,
  input  logic              iDataWe,
  input  logic [ADDR_W-1:0] iDataAddr,
  input  logic [DATA_W-1:0] iDataWData,
  output logic              oDataGnt,
  output logic [DATA_W-1:0] oDataRData,
  output logic              oDataValid,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [DATA_W-1:0] oMemData,
  input  logic [DATA_W-1:0] iMemData,
  output logic              oMemRead,
  output logic              oMemWrite,
  output logic              oBusy
);

  localparam logic IDLE      = 1'b0;
  localparam logic ACCESS    = 1'b1;
  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;
  localparam logic PRI_DATA  = (PRIORITY != 0);
  // The counter runs MEM_LAT-1 down to 0, so the strobes stay up MEM_LAT cycles.
  localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

  logic       state_r;
  logic [3:0] cnt_r;
  logic       owner_r;
  logic       last_gnt_r;
  logic       any_req_s;
  logic       pick_data_s;

  assign any_req_s = iFetchReq | iDataReq;

  // Choose the winner among the currently asserted requests.
  always_comb begin
    pick_data_s = 1'b0;
    if (iDataReq && iFetchReq) begin
      if (PRI_DATA) begin
        pick_data_s = 1'b1;
      end else begin
        // Round-robin: serve whichever port was not served most recently.
        pick_data_s = (last_gnt_r == OWN_FETCH);
      end
    end else begin
      pick_data_s = iDataReq;
    end
  end

  // Access sequencer: grant, hold the memory port, then return data.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      owner_r     <= OWN_FETCH;
      last_gnt_r  <= OWN_DATA;
      oFetchGnt   <= 1'b0;
      oDataGnt    <= 1'b0;
      oFetchValid <= 1'b0;
      oDataValid  <= 1'b0;
      oFetchRData <= {DATA_W{1'b0}};
      oDataRData  <= {DATA_W{1'b0}};
      oMemAddr    <= {ADDR_W{1'b0}};
      oMemData    <= {DATA_W{1'b0}};
      oMemRead    <= 1'b0;
      oMemWrite   <= 1'b0;
      oBusy       <= 1'b0;
    end else begin
      // Grant and valid are single-cycle pulses.
      oFetchGnt   <= 1'b0;
      oDataGnt    <= 1'b0;
      oFetchValid <= 1'b0;
      oDataValid  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            state_r <= ACCESS;
            cnt_r   <= CNT_LOAD;
            oBusy   <= 1'b1;
            owner_r <= pick_data_s;
            if (pick_data_s) begin
              oDataGnt <= 1'b1;
              oMemAddr <= iDataAddr;
              if (iDataWe) begin
                oMemWrite <= 1'b1;
                oMemRead  <= 1'b0;
                oMemData  <= iDataWData;
              end else begin
                oMemWrite <= 1'b0;
                oMemRead  <= 1'b1;
                oMemData  <= {DATA_W{1'b0}};
              end
            end else begin
              // Fetch is read-only; it never raises the write strobe.
              oFetchGnt <= 1'b1;
              oMemAddr  <= iFetchAddr;
              oMemRead  <= 1'b1;
              oMemWrite <= 1'b0;
              oMemData  <= {DATA_W{1'b0}};
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            state_r    <= IDLE;
            oBusy      <= 1'b0;
            oMemRead   <= 1'b0;
            oMemWrite  <= 1'b0;
            last_gnt_r <= owner_r;
            if (owner_r == OWN_DATA) begin
              oDataValid <= 1'b1;
              // A completed write keeps the last read data visible.
              if (!oMemWrite) begin
                oDataRData <= iMemData;
              end else begin
                oDataRData <= oDataRData;
              end
            end else begin
              oFetchValid <= 1'b1;
              oFetchRData <= iMemData;
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          oBusy     <= 1'b0;
          oMemRead  <= 1'b0;
          oMemWrite <= 1'b0;
        end
      endcase
    end
  end

  mem_port_arbiter_chk #(.MEM_LAT(MEM_LAT)) u_chk (
    .clk         (iClk),
    .rst         (iRst),
    .fetch_gnt   (oFetchGnt),
    .data_gnt    (oDataGnt),
    .fetch_valid (oFetchValid),
    .data_valid  (oDataValid),
    .mem_read    (oMemRead),
    .mem_write   (oMemWrite)
  );

endmodule

// Simulation-only properties of the arbiter: legal latency, exclusive pulses
// and strobes.
module mem_port_arbiter_chk #(
  parameter int MEM_LAT = 1
) (
  input logic clk,
  input logic rst,
  input logic fetch_gnt,
  input logic data_gnt,
  input logic fetch_valid,
  input logic data_valid,
  input logic mem_read,
  input logic mem_write
);

  a_lat_range: assert property (@(posedge clk) (MEM_LAT >= 1) && (MEM_LAT <= 15))
    else $error("mem_port_arbiter: MEM_LAT %0d outside 1..15", MEM_LAT);

  a_one_gnt: assert property (@(posedge clk) disable iff (rst) !(fetch_gnt && data_gnt));

  a_one_valid: assert property (@(posedge clk) disable iff (rst) !(fetch_valid && data_valid));

  a_one_strobe: assert property (@(posedge clk) disable iff (rst) !(mem_read && mem_write));

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single unified memory port between two requesters: instruction fetch and data load/store.
- Sits between the CPU core's fetch/data request interfaces and the external memory bus (oMemAddr/oMemData/iMemData/oMemRead/oMemWrite).
- Sequences one access at a time with a fixed, parameterised memory latency.
- Arbitrates simultaneous requests either round-robin or with fixed data priority.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, cycles the memory port is held per access before read data is captured. Legal range 1..15.
- PRIORITY, 0, arbitration mode. 0 = round-robin; 1 = data port always wins.

Ports:
- iClk  in  1  clock, rising edge.
- iRst  in  1  synchronous reset, active-high.
- iFetchReq  in  1  fetch read request (level).
- iFetchAddr  in  ADDR_W  fetch address.
- oFetchGnt  out  1  one-cycle pulse: fetch request accepted.
- oFetchRData  out  DATA_W  fetch read data.
- oFetchValid  out  1  one-cycle pulse: oFetchRData valid.
- iDataReq  in  1  data request (level).
- iDataWe  in  1  1 = write, 0 = read.
- iDataAddr  in  ADDR_W  data address.
- iDataWData  in  DATA_W  write data.
- oDataGnt  out  1  one-cycle pulse: data request accepted.
- oDataRData  out  DATA_W  data read data.
- oDataValid  out  1  one-cycle pulse: read data valid, or write complete.
- oMemAddr  out  ADDR_W  memory address.
- oMemData  out  DATA_W  memory write data.
- iMemData  in  DATA_W  memory read data.
- oMemRead  out  1  memory read strobe.
- oMemWrite  out  1  memory write strobe.
- oBusy  out  1  high while an access is in flight (state ACCESS).

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - All outputs are registered.
  - Reset (sync, iRst=1) sets state=IDLE, all strobes/pulses/oBusy=0, oMemAddr/oMemData/oFetchRData/oDataRData=0, cnt=0, and lastGnt=DATA.
- States: IDLE, ACCESS.
- IDLE, no request: outputs hold; strobes and pulses are 0.
- IDLE, any request sampled at edge E:
  - Select winner.
  - Latch address, we, wdata and owner.
  - At E: state<=ACCESS, cnt<=MEM_LAT-1, oBusy<=1, owner Gnt<=1 (for one cycle).
  - oMemAddr<=addr.
  - Read: oMemRead<=1, oMemData<=0.
  - Write: oMemWrite<=1, oMemData<=wdata.
- ACCESS, cnt!=0: cnt decrements; memory outputs held stable; Gnt<=0.
- ACCESS, cnt==0 at edge:
  - Owner RData<=iMemData on reads only; write leaves RData unchanged.
  - Owner Valid<=1 for one cycle.
  - oMemRead/oMemWrite<=0, oBusy<=0, state<=IDLE.
  - lastGnt<=owner (used by round-robin).
- Timing:
  - Request sampled at edge E → Gnt high in cycle E+1.
  - Strobe high for MEM_LAT cycles.
  - Valid high in cycle E+1+MEM_LAT.
  - Minimum spacing between grants is MEM_LAT+1 cycles. Arbitration occurs in the IDLE cycle in which Valid is high, so back-to-back accesses are possible.
- Handshake:
  - A requester holds Req/addr/we/wdata stable until it sees Gnt.
  - Req still high in any IDLE cycle is treated as a new request. A requester wanting one access must drop Req in the Gnt cycle.
  - Requests during ACCESS are ignored; they are not lost if still held at IDLE.
- Arbitration when both requests are high in IDLE:
  - PRIORITY=0: grant the port that is not lastGnt. After reset the first tie goes to fetch.
  - PRIORITY=1: data always wins; fetch may starve (accepted behaviour).
- Only one Gnt and one Valid may be high in any cycle. Fetch accesses never drive oMemWrite.
- Reset mid-ACCESS: abort immediately; no Valid pulse; strobes drop the next cycle. Requesters re-issue.
- Counter: 4-bit. MEM_LAT outside 1..15 is illegal; a simulation assertion fires.

Test Plan:
- MEM_LAT=1, memory model returns 0x12345678 at addr 0x0. Fetch req addr 0x0 at cycle 0 → oFetchGnt=1 and oMemRead=1 with oMemAddr=0x0 in cycle 1; oFetchValid=1 with oFetchRData=0x12345678 in cycle 2; oBusy=1 in cycle 1 only.
- Data write addr 0x100, wdata 0xDEADBEEF, MEM_LAT=3 → oMemWrite=1, oMemAddr=0x100, oMemData=0xDEADBEEF for exactly 3 cycles. oDataValid pulses in cycle 4. oDataRData unchanged. Fetch outputs stay 0.
- PRIORITY=0, fetch and data both held high from reset, MEM_LAT=1 → grant order is fetch, data, fetch, data. Grants on cycles 1, 3, 5, 7. Never two Gnt/Valid in the same cycle.
- PRIORITY=1, both held high → oDataGnt on every grant slot; oFetchGnt never asserted over 20 cycles. Drop iDataReq → fetch granted at the next IDLE.
- Data read addr 0x8, MEM_LAT=2. iRst asserted in the second ACCESS cycle → no oDataValid; oMemRead=0 and oBusy=0 the next cycle. A re-issued request completes normally.
- Fetch Req held high through ACCESS with MEM_LAT=4 → exactly one Gnt per 5 cycles. Memory address/strobes do not change during ACCESS even when iFetchAddr changes.
